// File: rtl/postprocess_pool_stream_if.sv
// Pixel stream interface for postprocess_pool_stream: input beat channel plus pooled output channel.
// A beat transfers on a rising clk edge where valid & ready; the sender holds data stable while valid & ~ready.
interface postprocess_pool_stream_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 9
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/postprocess_pool_stream.sv
// Streaming KxK stride-K pooling with a per-column row buffer and a single output register.
// Define POOL_AVG_EN to build the average datapath and frame mode latch; otherwise max-only.
module postprocess_pool_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL_K = 2,
  parameter int IDX_W  = 9
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic mode,
  postprocess_pool_stream_if.slave st,
  output logic busy
);
  localparam int LOG2K = (POOL_K == 4) ? 2 : 1;
`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_W + 2 * LOG2K;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int NCOL  = IMG_W / POOL_K;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int NOUT  = NCOL * (IMG_H / POOL_K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOUT - 1);

  if (POOL_K != 2 && POOL_K != 4) begin : g_bad_k
    $error("POOL_K must be 2 or 4");
  end
  if ((IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0) begin : g_bad_img
    $error("IMG_W and IMG_H must be multiples of POOL_K");
  end

  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic                     frame_q, frame_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_idx_q, out_idx_d;
  logic signed [ACC_W-1:0]  row_buf [NCOL];

  logic                     accept, first, complete, col_end, row_end, avg_sel;
  logic [LOG2K-1:0]         kx, ky;
  logic signed [ACC_W-1:0]  px_ext, entry, combined;
  logic signed [DATA_W-1:0] pooled;

  assign st.in_ready  = clear | ~out_valid_q | st.out_ready;
  assign accept       = st.in_valid & st.in_ready & ~clear;
  assign kx           = col_q[LOG2K-1:0];
  assign ky           = row_q[LOG2K-1:0];
  assign first        = (kx == '0) && (ky == '0);
  assign complete     = (&kx) && (&ky);
  assign col_end      = (col_q == COL_W'(IMG_W - 1));
  assign row_end      = (row_q == ROW_W'(IMG_H - 1));
  assign px_ext       = ACC_W'(st.in_data);
  assign entry        = row_buf[col_q[COL_W-1:LOG2K]];

`ifdef POOL_AVG_EN
  logic mode_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                                       mode_q <= 1'b0;
    else if (clear)                                   mode_q <= 1'b0;
    else if (accept && col_q == '0 && row_q == '0)    mode_q <= mode;
  end
  assign avg_sel = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign avg_sel     = 1'b0;
`endif

  always_comb begin
    combined = px_ext;
    if (!first) begin
      if (avg_sel)               combined = entry + px_ext;
      else if (px_ext > entry)   combined = px_ext;
      else                       combined = entry;
    end
    pooled = avg_sel ? DATA_W'(combined >>> (2 * LOG2K)) : DATA_W'(combined);
  end

  // Handshake drain and window load may coincide; the load wins so out_valid stays high.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    frame_d     = frame_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      frame_d     = 1'b0;
      out_valid_d = 1'b0;
      out_idx_d   = '0;
    end else begin
      if (out_valid_q && st.out_ready) begin
        out_valid_d = 1'b0;
        out_idx_d   = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + IDX_W'(1);
      end
      if (accept) begin
        frame_d = 1'b1;
        col_d   = col_end ? '0 : col_q + COL_W'(1);
        if (col_end) begin
          row_d = row_end ? '0 : row_q + ROW_W'(1);
          if (row_end) frame_d = 1'b0;
        end
        if (complete) begin
          out_valid_d = 1'b1;
          out_data_d  = pooled;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      col_q       <= '0;
      row_q       <= '0;
      frame_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) row_buf[col_q[COL_W-1:LOG2K]] <= combined;
  end

  assign st.out_valid = out_valid_q;
  assign st.out_data  = out_data_q;
  assign st.out_idx   = out_idx_q;
  assign st.out_last  = (out_idx_q == LAST_IDX);
  assign busy         = frame_q | out_valid_q;
endmodule
